mantissa_aligner: RTL and testbench

- Adder/subtractor stage directly downstream of the exponent-difference stage.
- Takes both 24-bit significands (hidden bit included) plus the Difference/Sign pair from that stage.
- Swaps the operands so the larger-exponent significand comes out unshifted.
- Right-shifts the smaller significand iteratively, up to MAX_STEP bits per cycle, producing a 27-bit aligned value with guard/round/sticky for the significand adder. Valid/ready handshake on both sides.

---
 rtl/fpu_add_pkg.sv | 22 ++
 rtl/mantissa_aligner_sticky_shift_step.sv | 31 +++
 rtl/mantissa_aligner.sv | 110 +++++++++++
 tb/tb_mantissa_aligner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_add_pkg.sv
// ---------------------------------------------------------------------------
// fpu_add_pkg
//   Shared constants and types for the floating-point adder datapath.
//   MANT_W      : significand width including the hidden bit
//   GRS_W       : guard/round/sticky extension appended below the significand
//   ALIGN_W     : width of the aligned (extended) significand
//   SHIFT_CLAMP : shifts at or beyond this distance only contribute sticky
// ---------------------------------------------------------------------------
package fpu_add_pkg;

  localparam int unsigned MANT_W      = 24;
  localparam int unsigned GRS_W       = 3;
  localparam int unsigned ALIGN_W     = MANT_W + GRS_W;
  localparam int unsigned SHIFT_CLAMP = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } aligner_state_t;

endpackage

// File: rtl/mantissa_aligner_sticky_shift_step.sv
// ---------------------------------------------------------------------------
// sticky_shift_step
//   One combinational right-shift step with sticky collection.
//   i_data  : ALIGN_W-bit value to shift
//   i_shamt : shift distance for this step (0..31, caller bounds it)
//   o_data  : i_data >> i_shamt, with bit0 ORed with every bit shifted out
// ---------------------------------------------------------------------------
module sticky_shift_step
  import fpu_add_pkg::*;
#(
  parameter int unsigned SHIFT_W = ALIGN_W
) (
  input  logic [SHIFT_W-1:0] i_data,
  input  logic [4:0]         i_shamt,
  output logic [SHIFT_W-1:0] o_data
);

  logic [SHIFT_W-1:0] w_ones;
  logic [SHIFT_W-1:0] w_lost;
  logic [SHIFT_W-1:0] w_shifted;

  always_comb begin
    w_ones    = '1;
    // Bits below the shift distance are the ones that fall off the end.
    w_lost    = i_data & ~(w_ones << i_shamt);
    w_shifted = i_data >> i_shamt;
    o_data    = w_shifted;
    o_data[0] = w_shifted[0] | (|w_lost);
  end

endmodule

// File: rtl/mantissa_aligner.sv
// ---------------------------------------------------------------------------
// mantissa_aligner
//   Swaps the two significands so the larger-exponent one passes unshifted,
//   then right-shifts the smaller one up to MAX_STEP bits per clock,
//   accumulating guard/round/sticky for the significand adder.
//
//   Clk, Rst_n       : rising-edge clock, asynchronous active-low reset
//   InValid/InReady  : input handshake (InReady only in IDLE)
//   Mantissa1/2      : significands including hidden bit
//   Difference       : |Exponent1 - Exponent2|
//   Sign             : 1 when Exponent1 < Exponent2
//   OutValid/OutReady: output handshake (OutValid only in DONE)
//   LargerMantissa   : unshifted larger-exponent significand
//   AlignedMantissa  : shifted smaller significand, [2:0] = G,R,S
//   Swapped          : registered Sign
// ---------------------------------------------------------------------------
module mantissa_aligner
  import fpu_add_pkg::*;
#(
  parameter int unsigned MANT_W   = fpu_add_pkg::MANT_W,
  parameter int unsigned MAX_STEP = 8
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                InValid,
  output logic                InReady,
  input  logic [MANT_W-1:0]   Mantissa1,
  input  logic [MANT_W-1:0]   Mantissa2,
  input  logic [7:0]          Difference,
  input  logic                Sign,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [MANT_W-1:0]   LargerMantissa,
  output logic [MANT_W+2:0]   AlignedMantissa,
  output logic                Swapped
);

  localparam int unsigned AW = MANT_W + GRS_W;

  aligner_state_t    r_state;
  aligner_state_t    w_next;
  logic [MANT_W-1:0] r_larger;
  logic [AW-1:0]     r_shift;
  logic              r_swapped;
  logic [4:0]        r_rem;

  logic [4:0]        w_clamp;
  logic [4:0]        w_k;
  logic [AW-1:0]     w_step_out;
  logic [MANT_W-1:0] w_small;
  logic              w_accept;

  assign InReady         = (r_state == IDLE);
  assign OutValid        = (r_state == DONE);
  assign LargerMantissa  = r_larger;
  assign AlignedMantissa = r_shift;
  assign Swapped         = r_swapped;

  assign w_accept = InValid && (r_state == IDLE);
  assign w_small  = Sign ? Mantissa1 : Mantissa2;
  // Every distance of SHIFT_CLAMP or more leaves only sticky, so 5 bits suffice.
  assign w_clamp  = (Difference >= 8'(SHIFT_CLAMP)) ? 5'(SHIFT_CLAMP) : Difference[4:0];
  assign w_k      = (r_rem > 5'(MAX_STEP)) ? 5'(MAX_STEP) : r_rem;

  sticky_shift_step #(
    .SHIFT_W (AW)
  ) u_step (
    .i_data  (r_shift),
    .i_shamt (w_k),
    .o_data  (w_step_out)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_clamp == 5'd0) ? DONE : SHIFT;
      SHIFT:   if (r_rem == w_k) w_next = DONE;
      DONE:    if (OutReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= IDLE;
      r_larger  <= '0;
      r_shift   <= '0;
      r_swapped <= 1'b0;
      r_rem     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_larger  <= Sign ? Mantissa2 : Mantissa1;
            r_shift   <= {w_small, {GRS_W{1'b0}}};
            r_swapped <= Sign;
            r_rem     <= w_clamp;
          end
        end
        SHIFT: begin
          r_shift <= w_step_out;
          r_rem   <= r_rem - w_k;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_aligner.sv
module tb_mantissa_aligner;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        InValid;
  logic        InReady;
  logic [23:0] Mantissa1;
  logic [23:0] Mantissa2;
  logic [7:0]  Difference;
  logic        Sign;
  logic        OutValid;
  logic        OutReady;
  logic [23:0] LargerMantissa;
  logic [26:0] AlignedMantissa;
  logic        Swapped;

  int errors = 0;
  int checks = 0;

  mantissa_aligner #(
    .MANT_W   (24),
    .MAX_STEP (8)
  ) dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .InValid         (InValid),
    .InReady         (InReady),
    .Mantissa1       (Mantissa1),
    .Mantissa2       (Mantissa2),
    .Difference      (Difference),
    .Sign            (Sign),
    .OutValid        (OutValid),
    .OutReady        (OutReady),
    .LargerMantissa  (LargerMantissa),
    .AlignedMantissa (AlignedMantissa),
    .Swapped         (Swapped)
  );

  always #5 Clk = ~Clk;

  // Reference: a full-width shift where any bit that falls off sets the LSB.
  function automatic logic [26:0] ref_aligned(input logic [23:0] m, input logic [7:0] d);
    longint unsigned v, lost, res;
    int unsigned sh;
    v    = longint'({m, 3'b000});
    sh   = (d > 8'd27) ? 27 : int'(d);
    lost = v & ((64'd1 << sh) - 64'd1);
    res  = (v >> sh) | ((lost != 0) ? 64'd1 : 64'd0);
    return res[26:0];
  endfunction

  function automatic int ref_latency(input logic [7:0] d);
    int unsigned sh;
    sh = (d > 8'd27) ? 27 : int'(d);
    return 1 + int'((sh + 7) / 8);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Start one operation and wait for OutValid; OutValid is left pending.
  task automatic start_and_wait(input logic [23:0] m1, input logic [23:0] m2,
                                input logic [7:0] d, input logic s, input string tag);
    int n;
    int lat;
    logic [26:0] exp_al;
    logic [23:0] exp_lg;
    n = 0;
    while (!InReady && n < 50) begin step(); n++; end
    checks++;
    if (!InReady) begin
      errors++;
      $display("FAIL %s_ready: InReady=%0b required 1", tag, InReady);
    end
    Mantissa1 = m1; Mantissa2 = m2; Difference = d; Sign = s; InValid = 1'b1;
    step();
    InValid = 1'b0;
    Mantissa1 = $urandom; Mantissa2 = $urandom; Difference = $urandom; Sign = $urandom;
    lat = 1;
    while (!OutValid && lat < 40) begin step(); lat++; end
    exp_al = ref_aligned(s ? m1 : m2, d);
    exp_lg = s ? m2 : m1;
    checks++;
    if (lat !== ref_latency(d)) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", tag, lat, ref_latency(d));
    end
    checks++;
    if (AlignedMantissa !== exp_al) begin
      errors++;
      $display("FAIL %s_aligned: got %h required %h", tag, AlignedMantissa, exp_al);
    end
    checks++;
    if (LargerMantissa !== exp_lg || Swapped !== s) begin
      errors++;
      $display("FAIL %s_larger: got %h/%0b required %h/%0b", tag,
               LargerMantissa, Swapped, exp_lg, s);
    end
  endtask

  task automatic finish_op(input string tag);
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    checks++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: InReady=%0b OutValid=%0b required 1/0", tag, InReady, OutValid);
    end
  endtask

  task automatic run_op(input logic [23:0] m1, input logic [23:0] m2,
                        input logic [7:0] d, input logic s, input string tag);
    start_and_wait(m1, m2, d, s, tag);
    finish_op(tag);
  endtask

  task automatic check_cleared(input string tag);
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || LargerMantissa !== 24'h0 ||
        AlignedMantissa !== 27'h0 || Swapped !== 1'b0) begin
      errors++;
      $display("FAIL %s: OV=%0b IR=%0b L=%h A=%h S=%0b required 0/1/0/0/0", tag,
               OutValid, InReady, LargerMantissa, AlignedMantissa, Swapped);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) step();
    check_cleared("reset_initial");
    Rst_n = 1'b1;
    step();
    Mantissa1 = 24'h123456; Mantissa2 = 24'hABCDEF; Difference = 8'd20; Sign = 1'b0;
    InValid = 1'b1;
    step();
    InValid = 1'b0;
    step();
    #2 Rst_n = 1'b0;
    #1;
    check_cleared("reset_async");
    step();
    step();
    Rst_n = 1'b1;
    step();
    check_cleared("reset_released");
    run_op(24'hFEDCBA, 24'h9ABCDE, 8'd13, 1'b1, "after_reset");
  endtask

  task automatic test_no_shift();
    start_and_wait(24'hC00000, 24'hA00000, 8'd0, 1'b0, "no_shift");
    checks++;
    if (AlignedMantissa !== 27'h5000000) begin
      errors++;
      $display("FAIL no_shift_const: got %h required 5000000", AlignedMantissa);
    end
    finish_op("no_shift");
  endtask

  task automatic test_swap();
    start_and_wait(24'h800000, 24'hC00000, 8'd2, 1'b1, "swap");
    checks++;
    if (AlignedMantissa !== 27'h1000000 || LargerMantissa !== 24'hC00000) begin
      errors++;
      $display("FAIL swap_const: got %h/%h required 1000000/c00000",
               AlignedMantissa, LargerMantissa);
    end
    finish_op("swap");
  endtask

  task automatic test_sticky();
    run_op(24'hFFFFFF, 24'h800000, 8'd10, 1'b0, "sticky_a");
    run_op(24'h000000, 24'hFFFFFF, 8'd10, 1'b0, "sticky_b");
    run_op(24'h800001, 24'h000000, 8'd17, 1'b1, "sticky_c");
    run_op(24'h123457, 24'h000000, 8'd8, 1'b1, "sticky_d");
  endtask

  task automatic test_clamp();
    start_and_wait(24'h400000, 24'h000001, 8'd200, 1'b0, "clamp_one");
    checks++;
    if (AlignedMantissa !== 27'h0000001) begin
      errors++;
      $display("FAIL clamp_one_const: got %h required 0000001", AlignedMantissa);
    end
    finish_op("clamp_one");
    run_op(24'h400000, 24'h000000, 8'd200, 1'b0, "clamp_zero");
    run_op(24'hFFFFFF, 24'h800000, 8'd27, 1'b0, "clamp_27");
    run_op(24'hFFFFFF, 24'hFFFFFF, 8'd26, 1'b1, "clamp_26");
    run_op(24'h000001, 24'hFFFFFF, 8'd255, 1'b0, "clamp_255");
  endtask

  task automatic test_backpressure();
    logic [23:0] lg;
    logic [26:0] al;
    logic        sw;
    start_and_wait(24'h654321, 24'hFEDCBA, 8'd5, 1'b1, "bp");
    lg = LargerMantissa; al = AlignedMantissa; sw = Swapped;
    for (int i = 0; i < 6; i++) begin
      Mantissa1 = $urandom; Mantissa2 = $urandom; Difference = $urandom; Sign = $urandom;
      InValid = 1'b1;
      step();
      checks++;
      if (OutValid !== 1'b1 || InReady !== 1'b0 || LargerMantissa !== lg ||
          AlignedMantissa !== al || Swapped !== sw) begin
        errors++;
        $display("FAIL bp_hold%0d: OV=%0b IR=%0b A=%h required 1/0/%h", i,
                 OutValid, InReady, AlignedMantissa, al);
      end
    end
    InValid = 1'b0;
    finish_op("bp");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = (i % 4 == 0) ? 8'($urandom_range(27, 255)) : 8'($urandom_range(0, 30));
      run_op(24'($urandom), 24'($urandom), d, 1'($urandom), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    Rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    Mantissa1 = '0; Mantissa2 = '0; Difference = '0; Sign = 1'b0;
    test_reset();
    test_no_shift();
    test_swap();
    test_sticky();
    test_clamp();
    test_backpressure();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
